// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial 8N1 program loader writing 6-bit instructions into program memory
module prog_loader #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [5:0] wr_data,
  output logic       cpu_halt,
  output logic       busy,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    sync_ok_q;
  logic          rx_fall;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [5:0]    wr_data_q, wr_data_d;
  logic          halt_q, halt_d;
  logic          ferr_q, ferr_d;

  // Two-flop synchronizer plus edge history. The history flop only takes a
  // high value once the synchronizer holds real line samples, so a line that
  // is already low when reset releases never looks like a fresh start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b0;
      sync_ok_q <= 2'b00;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      sync_ok_q <= {sync_ok_q[0], 1'b1};
      rx_prev_q <= sync_ok_q[1] & rx_s2_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 6'd0;
      halt_q    <= 1'b1;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      halt_q    <= halt_d;
      ferr_q    <= ferr_d;
    end
  end

  // Receive FSM, bit timing and command decode of a completed byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    halt_d    = halt_q;
    ferr_d    = 1'b0;

    // Auto-increment lands the cycle after the write strobe.
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + 5'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s2_q) begin
            case (shift_q[7:6])
              2'b00: wr_addr_d = shift_q[4:0];
              2'b01: begin
                wr_en_d   = 1'b1;
                wr_data_d = shift_q[5:0];
              end
              2'b10: halt_d = 1'b0;
              default: halt_d = 1'b1;
            endcase
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_halt  = halt_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  localparam int CLKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [5:0] wr_data;
  logic       cpu_halt;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int         wr_cnt     = 0;
  int         wr_double  = 0;
  int         ferr_cnt   = 0;
  int         busy_cnt   = 0;
  logic       wr_en_prev = 1'b0;
  logic [4:0] last_addr  = 5'd0;
  logic [5:0] last_data  = 6'd0;

  int w0, f0, b0;

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(CLKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Observe strobes away from the active edge: count high cycles and capture
  // the address/data seen with each write strobe.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= wr_addr;
      last_data <= wr_data;
    end
    if (wr_en && wr_en_prev) wr_double <= wr_double + 1;
    wr_en_prev <= wr_en;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bits(b, 8);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state reached with no clock edge (first posedge is at 5).
    #1 rst = 1'b1;
    #2;
    check("rst_wr_en",     32'(wr_en),     0);
    check("rst_wr_addr",   32'(wr_addr),   0);
    check("rst_wr_data",   32'(wr_data),   0);
    check("rst_cpu_halt",  32'(cpu_halt),  1);
    check("rst_busy",      32'(busy),      0);
    check("rst_frame_err", 32'(frame_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(4);

    // WRITE 0x05 at address 0.
    w0 = wr_cnt;
    send_byte(8'h45, 1'b1);
    idle(4);
    check("w45_pulses",  32'(wr_cnt - w0), 1);
    check("w45_addr",    32'(last_addr),   0);
    check("w45_data",    32'(last_data),   32'h05);
    check("w45_addr_inc", 32'(wr_addr),    1);
    check("w45_data_hold", 32'(wr_data),   32'h05);

    // SET_ADDR 31, WRITE 0x3F, WRITE 0x00 across the wrap, back to back.
    w0 = wr_cnt;
    send_byte(8'h1F, 1'b1);
    send_byte(8'h7F, 1'b1);
    idle(4);
    check("wrap_addr31",   32'(last_addr), 31);
    check("wrap_data3f",   32'(last_data), 32'h3F);
    check("wrap_addr_to0", 32'(wr_addr),   0);
    send_byte(8'h40, 1'b1);
    idle(4);
    check("wrap_addr0",    32'(last_addr), 0);
    check("wrap_data00",   32'(last_data), 0);
    check("wrap_final",    32'(wr_addr),   1);
    check("wrap_pulses",   32'(wr_cnt - w0), 2);
    check("single_cycle_we", 32'(wr_double), 0);

    // RUN then HALT, with no writes.
    w0 = wr_cnt;
    send_bits(8'h80, 8);
    check("run_before_stop", 32'(cpu_halt), 1);
    drive_bit(1'b1);
    check("run_after_stop",  32'(cpu_halt), 0);
    send_byte(8'hC0, 1'b1);
    idle(4);
    check("halt_set",        32'(cpu_halt), 1);
    check("runhalt_no_we",   32'(wr_cnt - w0), 0);

    // Bad stop bit, then a valid WRITE 0x06.
    w0 = wr_cnt;
    f0 = ferr_cnt;
    send_byte(8'h45, 1'b0);
    idle(4);
    check("ferr_pulse",     32'(ferr_cnt - f0), 1);
    check("ferr_no_we",     32'(wr_cnt - w0),   0);
    check("ferr_addr_keep", 32'(wr_addr),       1);
    send_byte(8'h46, 1'b1);
    idle(4);
    check("after_ferr_addr", 32'(last_addr), 1);
    check("after_ferr_data", 32'(last_data), 32'h06);
    check("after_ferr_inc",  32'(wr_addr),   2);
    check("after_ferr_one",  32'(ferr_cnt - f0), 1);

    // Short low glitch on an idle line.
    w0 = wr_cnt;
    f0 = ferr_cnt;
    b0 = busy_cnt;
    rx = 1'b0;
    repeat (CLKS / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check("glitch_seen",    32'(busy_cnt > b0), 1);
    check("glitch_idle",    32'(busy),          0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 0);
    check("glitch_no_we",   32'(wr_cnt - w0),   0);

    // Reset in the middle of data bit 4 of a WRITE frame.
    send_byte(8'h80, 1'b1);
    idle(4);
    w0 = wr_cnt;
    f0 = ferr_cnt;
    send_bits(8'h45, 4);
    rx = 1'b0;
    repeat (CLKS / 2) @(negedge clk);
    check("midframe_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("arst_wr_addr",   32'(wr_addr),   0);
    check("arst_wr_data",   32'(wr_data),   0);
    check("arst_cpu_halt",  32'(cpu_halt),  1);
    check("arst_busy",      32'(busy),      0);
    check("arst_wr_en",     32'(wr_en),     0);
    check("arst_frame_err", 32'(frame_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b0 = busy_cnt;
    repeat (3 * CLKS) @(negedge clk);
    check("low_line_no_start", 32'(busy_cnt - b0), 0);
    idle(2 * CLKS);
    check("arst_no_we",   32'(wr_cnt - w0),   0);
    check("arst_no_ferr", 32'(ferr_cnt - f0), 0);
    w0 = wr_cnt;
    send_byte(8'h45, 1'b1);
    idle(4);
    check("post_rst_pulses", 32'(wr_cnt - w0), 1);
    check("post_rst_addr",   32'(last_addr),   0);
    check("post_rst_data",   32'(last_data),   32'h05);
    check("post_rst_inc",    32'(wr_addr),     1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
